// File: rtl/thresh_status_fifo_if.sv
// thresh_status_fifo_if: write/read handshake bundle between producer, FIFO and consumer.
interface thresh_status_fifo_if #(
   parameter int DATA_W = 32
);
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   modport master (output wr_valid, wr_data, rd_ready, input wr_ready, rd_valid, rd_data);
   modport slave  (input wr_valid, wr_data, rd_ready, output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/thresh_status_fifo.sv
// thresh_status_fifo: show-ahead FIFO with registered fill status word and almost-empty event.
module thresh_status_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                pclk,
   input  logic                preset_n,
   input  logic                flush,
   thresh_status_fifo_if.slave bus,
   input  logic [15:0]         cfg_threshold,
   output logic [15:0]         empty_state,
   output logic                thresh_irq
);
   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   level;
   logic [ADDR_W:0]   level_nxt;
   logic              wr_acc;
   logic              rd_acc;
   logic              below_nxt;
   assign bus.wr_ready = level != FULL;
   assign bus.rd_valid = level != '0;
   assign bus.rd_data  = mem[rd_ptr];
   assign wr_acc       = bus.wr_valid & bus.wr_ready;
   assign rd_acc       = bus.rd_valid & bus.rd_ready;
   assign level_nxt    = flush ? '0 : level + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
   assign below_nxt    = 16'(level_nxt) <= cfg_threshold;
   always_ff @(posedge pclk)
      if (wr_acc & ~flush) mem[wr_ptr] <= bus.wr_data;
   // empty_state[13] holds last cycle's below, so a fresh 0->1 edge is an event unless flush caused it
   always_ff @(posedge pclk or negedge preset_n)
      if (!preset_n) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         level       <= '0;
         empty_state <= 16'hA000;
         thresh_irq  <= 1'b0;
      end else begin
         rd_ptr      <= flush ? '0 : rd_ptr + ADDR_W'(rd_acc);
         wr_ptr      <= flush ? '0 : wr_ptr + ADDR_W'(wr_acc);
         level       <= level_nxt;
         empty_state <= {level_nxt == '0, level_nxt == FULL, below_nxt, 5'b0, 8'(level_nxt)};
         thresh_irq  <= ~flush & ~empty_state[13] & below_nxt;
      end
endmodule

// File: tb/tb_thresh_status_fifo.sv
// tb_thresh_status_fifo: directed plus random checks of thresh_status_fifo against a queue model.
module tb_thresh_status_fifo;
   logic        pclk = 1'b0;
   logic        preset_n = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] cfg = 16'd0;
   logic [15:0] empty_state;
   logic        thresh_irq;
   thresh_status_fifo_if #(.DATA_W(32)) bus ();
   thresh_status_fifo #(.DATA_W(32), .DEPTH(16)) dut (
      .pclk(pclk), .preset_n(preset_n), .flush(flush), .bus(bus),
      .cfg_threshold(cfg), .empty_state(empty_state), .thresh_irq(thresh_irq)
   );
   always #5 pclk = ~pclk;
   int          n_chk = 0;
   int          n_pass = 0;
   int          irq_cnt = 0;
   logic [31:0] q [$];
   logic        m_below = 1'b1;
   logic        m_irq = 1'b0;
   logic [31:0] seq = 32'h0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %h exp %h", tag, got, exp);
   endtask
   task automatic model_reset();
      q.delete();
      m_below = 1'b1;
      m_irq = 1'b0;
   endtask
   task automatic chk_status(input string tag);
      int n;
      n = q.size();
      chk({tag, "_state"}, {16'h0, empty_state},
          {16'h0, n == 0, n == 16, m_below, 5'b0, 8'(n)});
      chk({tag, "_irq"}, {31'h0, thresh_irq}, {31'h0, m_irq});
   endtask
   task automatic tick(input logic wv, input logic [31:0] wd, input logic rr, input logic fl);
      logic wacc, racc, nb;
      bus.wr_valid = wv;
      bus.wr_data  = wd;
      bus.rd_ready = rr;
      flush        = fl;
      #1;
      chk("wr_ready", {31'h0, bus.wr_ready}, {31'h0, q.size() < 16});
      chk("rd_valid", {31'h0, bus.rd_valid}, {31'h0, q.size() > 0});
      if (q.size() > 0) chk("rd_data", bus.rd_data, q[0]);
      wacc = wv && q.size() < 16;
      racc = rr && q.size() > 0;
      @(posedge pclk);
      if (fl) q.delete();
      else begin
         if (racc) void'(q.pop_front());
         if (wacc) q.push_back(wd);
      end
      nb = 16'(q.size()) <= cfg;
      m_irq = !fl && !m_below && nb;
      m_below = nb;
      @(negedge pclk);
      chk_status("tick");
      if (thresh_irq) irq_cnt++;
   endtask
   task automatic fill(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1'b1, seq, 1'b0, 1'b0);
         seq++;
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.rd_ready = 1'b0;
      model_reset();
      @(negedge pclk);
      chk("rst_wr_ready", {31'h0, bus.wr_ready}, 32'h1);
      chk("rst_rd_valid", {31'h0, bus.rd_valid}, 32'h0);
      chk_status("rst");
      preset_n = 1'b1;
      // 16 back-to-back writes, then an ignored 17th
      seq = 0;
      fill(16);
      chk("full_state", {16'h0, empty_state}, 32'h4010);
      tick(1'b1, 32'hBAD0_0017, 1'b0, 1'b0);
      chk("full_hold", {16'h0, empty_state}, 32'h4010);
      // drain in 16 cycles
      for (int i = 0; i < 16; i++) begin
         chk("drain_seq", bus.rd_data, i);
         tick(1'b0, 32'h0, 1'b1, 1'b0);
      end
      chk("drained", {16'h0, empty_state}, 32'hA000);
      chk("drained_valid", {31'h0, bus.rd_valid}, 32'h0);
      // threshold 4: fill to 8, read down, one irq
      cfg = 16'd4;
      fill(8);
      irq_cnt = 0;
      for (int i = 0; i < 8; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
      chk("thr4_irq_once", irq_cnt, 1);
      // level 3 with 20 cycles of simultaneous write+read
      fill(3);
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, seq, 1'b1, 1'b0);
         seq++;
      end
      chk("rw_level3", {24'h0, empty_state[7:0]}, 32'd3);
      fill(13);
      tick(1'b1, 32'hBAD0_0018, 1'b1, 1'b0);
      chk("full_rw_level", {24'h0, empty_state[7:0]}, 32'd15);
      chk("full_rw_ready", {31'h0, bus.wr_ready}, 32'h1);
      // threshold change 2 -> 10 at level 6
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      cfg = 16'd2;
      fill(6);
      irq_cnt = 0;
      cfg = 16'd10;
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      chk("cfg_irq_once", irq_cnt, 1);
      // flush with a write at level 6: no irq, flushed word never read
      cfg = 16'd2;
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      irq_cnt = 0;
      tick(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
      chk("flush_level", {24'h0, empty_state[7:0]}, 32'd0);
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      chk("flush_no_irq", irq_cnt, 0);
      fill(2);
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      // async reset mid-stream at level 9
      fill(9);
      bus.wr_valid = 1'b1;
      bus.rd_ready = 1'b1;
      #1 preset_n = 1'b0;
      #1;
      model_reset();
      chk("arst_wr_ready", {31'h0, bus.wr_ready}, 32'h1);
      chk("arst_rd_valid", {31'h0, bus.rd_valid}, 32'h0);
      chk("arst_state", {16'h0, empty_state}, 32'hA000);
      chk("arst_irq", {31'h0, thresh_irq}, 32'h0);
      bus.wr_valid = 1'b0;
      bus.rd_ready = 1'b0;
      @(negedge pclk);
      chk_status("arst_hold");
      preset_n = 1'b1;
      // random traffic with occasional flush and threshold changes
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) cfg = 16'($urandom_range(0, 20));
         tick(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 31) == 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
